// File: rtl/aclk_timegen.sv
// Time-base generator for the alarm clock: divides the system clock into
// single-cycle one_second and one_minute strobes. fastwatch makes the minute
// strobe follow the second strobe; reset_count re-aligns the time base.
module aclk_timegen #(
   parameter int CLKS_PER_SEC = 256,  // power of two, >= 2
   parameter int SECS_PER_MIN = 60,
   parameter int CNT_W        = 14    // 2**CNT_W >= CLKS_PER_SEC*SECS_PER_MIN
) (
   input  logic clock,
   input  logic reset,        // synchronous, active low
   input  logic reset_count,  // synchronous, active high
   input  logic fastwatch,
   output logic one_minute,
   output logic one_second
);

   // Last count value of a minute, and the mask selecting the within-second
   // part of the count (CLKS_PER_SEC is a power of two, so mod is a mask).
   localparam logic [CNT_W-1:0] TERM     = CNT_W'(CLKS_PER_SEC * SECS_PER_MIN - 1);
   localparam logic [CNT_W-1:0] SEC_MASK = CNT_W'(CLKS_PER_SEC - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO     = CNT_W'(0);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             second_next;
   logic             minute_next;

   // True when the count sits on the last cycle of a second.
   function automatic logic is_sec_term(input logic [CNT_W-1:0] c);
      return ((c & SEC_MASK) == SEC_MASK);
   endfunction

   // True when the count sits on the last cycle of a minute.
   function automatic logic is_min_term(input logic [CNT_W-1:0] c);
      return (c == TERM);
   endfunction

   // Free-running next-state values; the clears are applied in the register.
   always_comb begin
      count_next  = ZERO;
      second_next = 1'b0;
      minute_next = 1'b0;
      if (is_min_term(count)) begin
         count_next = ZERO;
      end else begin
         count_next = count + ONE;
      end
      second_next = is_sec_term(count);
      if (fastwatch) begin
         minute_next = is_sec_term(count);
      end else begin
         minute_next = is_min_term(count);
      end
   end

   // State and strobe registers with reset taking priority over reset_count;
   // a clear also drops any strobe that would have fired on this edge.
   always_ff @(posedge clock) begin
      if (!reset) begin
         count      <= ZERO;
         one_second <= 1'b0;
         one_minute <= 1'b0;
      end else if (reset_count) begin
         count      <= ZERO;
         one_second <= 1'b0;
         one_minute <= 1'b0;
      end else begin
         count      <= count_next;
         one_second <= second_next;
         one_minute <= minute_next;
      end
   end

endmodule

// File: tb/tb_aclk_timegen.sv
// Self-checking bench for aclk_timegen: directed scenarios followed by
// randomized clears and fastwatch toggles, compared every cycle against an
// elapsed-time model.
module tb_aclk_timegen;

   logic clock = 1'b0;
   logic reset;
   logic reset_count;
   logic fastwatch;
   logic one_minute;
   logic one_second;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model: cycles elapsed since the last clear, plus expected strobes.
   int t     = 0;
   bit e_sec = 1'b0;
   bit e_min = 1'b0;

   int sec_seen = 0;
   int min_seen = 0;

   aclk_timegen dut (
      .clock       (clock),
      .reset       (reset),
      .reset_count (reset_count),
      .fastwatch   (fastwatch),
      .one_minute  (one_minute),
      .one_second  (one_second)
   );

   // 10-unit clock period.
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n clock edges, updating the model and checking after each edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         if (!reset || reset_count) begin
            t     = 0;
            e_sec = 1'b0;
            e_min = 1'b0;
         end else begin
            t     = t + 1;
            e_sec = (t % 256) == 0;
            e_min = fastwatch ? e_sec : ((t % 15360) == 0);
         end
         #1;
         check("count", 32'(dut.count), 32'(t % 15360));
         check("one_second", {31'd0, one_second}, {31'd0, e_sec});
         check("one_minute", {31'd0, one_minute}, {31'd0, e_min});
         if (one_second === 1'b1) sec_seen++;
         if (one_minute === 1'b1) min_seen++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step(1);
      reset = 1'b1;
   endtask

   initial begin
      reset       = 1'b0;
      reset_count = 1'b0;
      fastwatch   = 1'b0;

      // Reset held for two edges, then a full minute in normal mode.
      step(2);
      reset    = 1'b1;
      sec_seen = 0;
      min_seen = 0;
      step(3);
      check("count_after_release", 32'(dut.count), 32'd3);
      step(15357);
      check("sec_pulses_per_minute", 32'(sec_seen), 32'd60);
      check("min_pulses_per_minute", 32'(min_seen), 32'd1);

      // fastwatch: 700 cycles from reset give two coincident pulses.
      do_reset();
      fastwatch = 1'b1;
      sec_seen  = 0;
      min_seen  = 0;
      step(700);
      check("fast_sec_pulses", 32'(sec_seen), 32'd2);
      check("fast_min_pulses", 32'(min_seen), 32'd2);

      // reset_count at count 200 re-aligns the next second strobe.
      fastwatch = 1'b0;
      do_reset();
      step(200);
      check("count_before_clear", 32'(dut.count), 32'd200);
      reset_count = 1'b1;
      step(1);
      reset_count = 1'b0;
      check("count_after_clear", 32'(dut.count), 32'd0);
      sec_seen = 0;
      step(255);
      check("no_sec_at_old_boundary", 32'(sec_seen), 32'd0);
      step(1);
      check("sec_256_after_clear", 32'(sec_seen), 32'd1);

      // Reset at count 255 suppresses the pending strobe.
      do_reset();
      step(255);
      check("count_at_255", 32'(dut.count), 32'd255);
      reset    = 1'b0;
      sec_seen = 0;
      min_seen = 0;
      step(1);
      check("suppressed_sec", {31'd0, one_second}, 32'd0);
      check("count_after_mid_reset", 32'(dut.count), 32'd0);
      reset = 1'b1;
      step(256);
      check("sec_after_mid_reset", 32'(sec_seen), 32'd1);

      // Random clears and fastwatch changes.
      for (int k = 0; k < 40; k++) begin
         fastwatch   = 1'($urandom_range(0, 1));
         reset_count = ($urandom_range(0, 7) == 0);
         reset       = ($urandom_range(0, 15) != 0);
         step(int'($urandom_range(1, 3)));
         reset_count = 1'b0;
         reset       = 1'b1;
         step(int'($urandom_range(1, 300)));
      end

      // Long run without clears, toggling fastwatch at random points.
      do_reset();
      for (int k = 0; k < 60; k++) begin
         fastwatch = 1'($urandom_range(0, 1));
         step(int'($urandom_range(1, 500)));
      end
      fastwatch = 1'b0;
      step(16000 - (t % 15360));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/aclk_timegen.md
Name: aclk_timegen

Overview:
- Time-base generator for the 24-hour alarm clock.
- Divides the fast system clock (nominally 256 Hz) into single-cycle one_second and one_minute strobes.
- The strobes feed the clock's time counters and alarm logic.
- fastwatch mode makes minutes advance once per second, for demo and test; reset_count lets the controller re-align the time base.

Parameters:
- CLKS_PER_SEC, 256, clock cycles per second; must be a power of two, >= 2.
- SECS_PER_MIN, 60, seconds per minute.
- CNT_W, 14, width of the internal counter; must satisfy 2^CNT_W >= CLKS_PER_SEC*SECS_PER_MIN.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset.
- reset_count  input  1  synchronous, active-high counter clear.
- fastwatch  input  1  1 = minute strobe follows the second strobe; 0 = normal minute.
- one_minute  output  1  single-cycle minute strobe, registered.
- one_second  output  1  single-cycle second strobe, registered.

Behaviour:
- Internal register count [CNT_W-1:0], hierarchically visible as count. TERM = CLKS_PER_SEC*SECS_PER_MIN-1, which is 15359 by default.
- Every rising edge evaluates the following in strict priority order:
  1. reset==0: count<=0, one_second<=0, one_minute<=0.
  2. else reset_count==1: count<=0, one_second<=0, one_minute<=0.
  3. else:
     - count <= (count==TERM) ? 0 : count+1.
     - one_second <= (count mod CLKS_PER_SEC == CLKS_PER_SEC-1), i.e. count[7:0]==8'hFF by default.
     - one_minute <= fastwatch ? (count mod CLKS_PER_SEC == CLKS_PER_SEC-1) : (count==TERM).
- Latency: a strobe is high during the one cycle immediately after the edge at which count held the terminal value. In that same cycle count reads the wrapped value (0 or a multiple of CLKS_PER_SEC).
- Strobe width is exactly one clock. With default parameters and no clears:
  - one_second period is 256 cycles.
  - one_minute period is 15360 cycles (fastwatch=0) or 256 cycles (fastwatch=1).
- fastwatch is sampled every cycle. Toggling it mid-minute takes effect on the next qualifying edge and does not disturb count.
- At count==TERM, one_second and one_minute (fastwatch=0) assert together in the same cycle.
- reset or reset_count asserted mid-operation aborts the current interval. The next one_second is then CLKS_PER_SEC cycles after release; any strobe pending for that edge is suppressed.
- There are no X outputs after the first edge with reset low. Before the first reset, values are undefined.

Test Plan:
- Reset: hold reset=0 for 2 edges, then release → count==0 and both outputs 0 while held. After release, count increments by 1 per cycle: 1, 2, 3, ….
- Second strobe, fastwatch=0: run 256 cycles from reset → one_second=1 for exactly one cycle, when count wraps 255→256. one_minute stays 0. Repeats every 256 cycles.
- Minute strobe, fastwatch=0: run 15360 cycles → one_minute=1 for one cycle, coincident with one_second, as count wraps 15359→0. No other one_minute pulses occur.
- fastwatch=1: run 700 cycles from reset → one_minute and one_second both pulse together 2 times, at the edges after count=255 and count=511.
- reset_count: pulse reset_count=1 for one cycle at count=200 → count==0 next cycle. The next one_second arrives 256 cycles after the clear, not at the old boundary.
- Mid-run reset: assert reset=0 at count=255 → no strobe is produced and count==0. Afterwards, normal timing resumes from 0.
